// File: rtl/dump_pkg.sv
// Shared types and defaults for the post-run data-memory dump controller.
// Included by the controller top and its testbench.
package dump_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_READ,
        ST_LATCH,
        ST_SEND,
        ST_FINISH,
        ST_GIVEUP
    } dump_state_t;

    localparam int CNT_W       = 16;
    localparam int DEF_BASE    = 0;
    localparam int DEF_LEN     = 256;
    localparam int DEF_TIMEOUT = 500;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping back to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Waits for the core to finish (or the watchdog to expire), then streams a
// window of data memory out one word at a time over a valid/ready port.
module dmem_dump_ctrl
    import dump_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int BASE    = DEF_BASE,
    parameter int LEN     = DEF_LEN,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              dump_done,
    output logic              timeout,
    output logic [15:0]       cycle_count
);

    // The index is one bit wider than an address so a full 2^ADDR_W dump can still end.
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(LEN - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam bit                TO_EN    = (TIMEOUT != 0);

    dump_state_t       state;
    dump_state_t       next_state;
    logic [ADDR_W:0]   index;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count;
    logic              cnt_en;
    logic              handshake;
    logic              last_word;

    assign rd_addr   = BASE_A + index[ADDR_W-1:0];
    assign cnt_en    = (state == ST_RUN) && !core_done;
    assign handshake = (state == ST_SEND) && out_ready;
    assign last_word = (index == LAST_IDX);

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (1'b0),
        .en   (cnt_en),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // core_done takes priority over the watchdog when both land in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN: begin
                if (core_done) begin
                    next_state = ST_READ;
                end else if (TO_EN && (count == TO_LAST)) begin
                    next_state = ST_GIVEUP;
                end
            end
            ST_READ:   next_state = ST_LATCH;
            ST_LATCH:  next_state = ST_SEND;
            ST_SEND: begin
                if (out_ready) begin
                    next_state = last_word ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: next_state = ST_FINISH;
            ST_GIVEUP: next_state = ST_GIVEUP;
            default:   next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (state == ST_LATCH) begin
                data_q <= mem_rdata;
                addr_q <= rd_addr;
            end
            if (handshake && !last_word) begin
                index <= index + 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out mid-reset.
    assign mem_rd_en   = !reset && (state == ST_READ);
    assign mem_addr    = mem_rd_en ? rd_addr : '0;
    assign out_valid   = !reset && (state == ST_SEND);
    assign out_addr    = reset ? '0 : addr_q;
    assign out_data    = reset ? '0 : data_q;
    assign dump_done   = !reset && (state == ST_FINISH);
    assign timeout     = !reset && (state == ST_GIVEUP);
    assign cycle_count = reset ? '0 : count;

endmodule

// File: doc/dmem_dump_ctrl.md
# dmem_dump_ctrl

Post-run controller on the observer side of the processor's `done` interface. It watches the core's `done` flag, runs a cycle watchdog, and then reads a window of data memory byte by byte. Each byte is streamed out over a valid/ready port to a checker or host. It sits beside `top` in the simulation and FPGA harness, replacing ad-hoc hierarchical peeks into data memory with a synthesizable readout path.

## Interface
Parameters:
- `ADDR_W`, default 8: data-memory address width.
- `DATA_W`, default 8: data-memory word width.
- `BASE`, default 0: first address dumped.
- `LEN`, default 256: number of words dumped, legal range 1..2^ADDR_W.
- `TIMEOUT`, default 500: maximum run cycles before giving up; 0 disables the watchdog.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `core_done`  in  1: level from the core; run finished.
- `mem_rd_en`  out  1: data-memory read strobe.
- `mem_addr`  out  ADDR_W: read address.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after `mem_rd_en`.
- `out_valid`  out  1: stream word available.
- `out_ready`  in  1: consumer accepts.
- `out_addr`  out  ADDR_W: address of `out_data`.
- `out_data`  out  DATA_W: dumped word.
- `dump_done`  out  1: sticky; all LEN words accepted.
- `timeout`  out  1: sticky; watchdog expired.
- `cycle_count`  out  16: run cycles counted.

## Operation
- States: RUN, READ, LATCH, SEND, FINISH, GIVEUP.
- RUN:
  - `cycle_count` increments each cycle, saturating at 0xFFFF.
  - `core_done`=1 → READ, with index=0 and count frozen.
  - Else, if TIMEOUT≠0 and `cycle_count`==TIMEOUT-1 → GIVEUP.
  - `core_done` wins if both occur in the same cycle.
- READ: `mem_rd_en`=1 and `mem_addr`=(BASE+index) mod 2^ADDR_W for exactly one cycle → LATCH.
- LATCH: register `mem_rdata` into `out_data` and `mem_addr` into `out_addr` → SEND.
- SEND:
  - `out_valid`=1, with `out_data`/`out_addr` held stable.
  - On `out_valid`&&`out_ready`: if index==LEN-1 → FINISH; else index+1 → READ.
  - `out_valid` never drops without a handshake.
- FINISH: `dump_done`=1 and `out_valid`=0; terminal until reset.
- GIVEUP: `timeout`=1; no memory reads; terminal until reset.
- After leaving RUN, `core_done` is ignored, including if it deasserts.
- Index counter width is ADDR_W+1 so that LEN=2^ADDR_W terminates correctly. Address arithmetic wraps modulo 2^ADDR_W; for example, BASE=0xF0 with LEN=32 reads 0xF0..0xFF, then 0x00..0x0F.

## Timing
- Every output is 0 during reset and on the first cycle after reset.
- Reset asserted in any state returns the block to RUN at the next edge. `out_valid`, `dump_done`, `timeout` and `cycle_count` clear, and no further `mem_rd_en` is issued.
- If `core_done` is sampled high at edge E, `mem_rd_en` is high in the cycle after E, and `out_valid` is first high 2 cycles after `mem_rd_en`.
- With `out_ready` held at 1, one word is transferred every 3 cycles. LEN words take 3·LEN cycles from the first READ to FINISH.
- `cycle_count` equals the number of RUN cycles seen before `core_done` was sampled.
- Back-pressure: each cycle of `out_ready`=0 in SEND adds exactly one cycle.

## Structure
- Shared package `dump_pkg`:
  - state enum typedef `dump_state_t`.
  - `CNT_W`=16.
  - default constants for BASE, LEN and TIMEOUT.
- One sub-module, `sat_counter` (parameterised width, enable, synchronous clear, saturate), used for `cycle_count`.
- The FSM and the index/address datapath live in `dmem_dump_ctrl`.

## Test plan
- Preload memory[i]=i^0x5A; `core_done` at cycle 10; `out_ready`=1 → 256 words with `out_data`=i^0x5A in address order; `cycle_count`=10; `dump_done` after 768 cycles.
- `core_done` never asserted, TIMEOUT=500 → `timeout`=1 at cycle 500; `mem_rd_en` never asserted; `dump_done`=0.
- `core_done` on the exact cycle the count reaches 499 → dump proceeds and `timeout` stays 0.
- BASE=0xF0, LEN=32, `out_ready` toggling 1,0,0 → addresses 0xF0..0xFF then 0x00..0x0F; data stable while stalled; no word lost or duplicated.
- Reset pulsed in SEND at word 5 → `out_valid`=0 next cycle and FSM back in RUN; a fresh `core_done` restarts the dump at BASE.
- LEN=1, BASE=0x7F → exactly one `mem_rd_en`; `out_addr`=0x7F; `dump_done` 3 cycles after READ.
